// File: rtl/rv523_ifetch_pkg.sv
// Shared types and constants for the RV523 instruction-fetch front end.
package rv523_ifetch_pkg;

  typedef enum logic [0:0] {
    StFetch,
    StHold
  } ifetch_state_e;

  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam logic [1:0]  OPC_FULL_LSB    = 2'b11;
  localparam int unsigned PC_INCR         = 4;

endpackage

// File: rtl/ifetch_assembler.sv
// Assembles 32-bit instructions from four byte reads and hands them to decode
// over a valid/ready handshake; owns the fetch PC and accepts redirects.
module ifetch_assembler
  import rv523_ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              instr_illegal
);

  localparam logic [1:0] LastIdx = 2'(BYTES_PER_INSTR - 1);

  ifetch_state_e     state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        idx_q, idx_d;
  logic              req_q, req_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;

  // Redirect targets are word aligned; the low bits are intentionally dropped.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    req_d   = req_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (redirect) begin
      // Redirect beats both a same-cycle ack and a same-cycle decode accept.
      state_d = StFetch;
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      idx_d   = 2'd0;
      req_d   = 1'b1;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          req_d = 1'b1;
          if (req_q && mem_ack) begin
            instr_d[{idx_q, 3'b000} +: 8] = mem_rdata;
            idx_d = idx_q + 2'd1;
            if (idx_q == LastIdx) begin
              state_d = StHold;
              req_d   = 1'b0;
              valid_d = 1'b1;
              ipc_d   = pc_q;
            end
          end
        end
        StHold: begin
          if (instr_ready) begin
            state_d = StFetch;
            pc_d    = pc_q + ADDR_W'(PC_INCR);
            idx_d   = 2'd0;
            req_d   = 1'b1;
            valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      idx_q   <= 2'd0;
      req_q   <= 1'b0;
      instr_q <= 32'h0;
      ipc_q   <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = pc_q + ADDR_W'(idx_q);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  // Gated by valid so the idle/reset value of the flag reads as legal.
  assign instr_illegal = valid_q && (instr_q[1:0] != OPC_FULL_LSB);

endmodule

// File: tb/tb_ifetch_assembler.sv
// Bench for ifetch_assembler: directed latency/redirect/wrap/reset scenarios,
// then randomized traffic checked against an instruction-level memory model.
module tb_ifetch_assembler;

  localparam logic [15:0] STALL_ADDR = 16'h0006;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h0;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        instr_illegal;

  always #5 clk = ~clk;

  ifetch_assembler #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_illegal (instr_illegal)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_retired = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: a fixed pattern with a few directed overrides.
  logic [7:0] mem_ovr [logic [15:0]];

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return a[7:0] ^ (a[15:8] * 8'd3) ^ 8'hA7;
  endfunction

  function automatic logic [31:0] mem_word(input logic [15:0] p);
    return {mem_byte(p + 16'd3), mem_byte(p + 16'd2), mem_byte(p + 16'd1), mem_byte(p)};
  endfunction

  // Memory responder: drives ack/data just after each rising edge.
  bit rand_mode = 1'b0;
  int stall_left = 3;
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (rand_mode) mem_ack = ($urandom_range(2) != 0);
      else if (mem_addr == STALL_ADDR && stall_left > 0) begin
        mem_ack = 1'b0;
        stall_left--;
      end else mem_ack = 1'b1;
      mem_rdata = mem_ack ? mem_byte(mem_addr) : 8'($urandom);
    end else begin
      // Stray acks with no request must be ignored.
      mem_ack   = 1'($urandom_range(1));
      mem_rdata = 8'($urandom);
    end
  end

  // Instruction-level reference: the retired stream is the memory word at a PC
  // that advances by 4 per accepted instruction and jumps on redirect.
  logic [15:0] exp_pc = 16'h0;
  int          nbytes = 0;
  always @(negedge clk) begin
    logic [31:0] w;
    #2;
    if (!rst_n) begin
      exp_pc = 16'h0;
      nbytes = 0;
    end else begin
      if (instr_valid) check_eq("hold_no_req", 32'(mem_req), 32'd0);
      if (redirect) begin
        exp_pc = {redirect_pc[15:2], 2'b00};
        nbytes = 0;
      end else begin
        if (mem_req && mem_ack) begin
          check_eq("fetch_addr", 32'(mem_addr), 32'(exp_pc + 16'(nbytes)));
          nbytes++;
        end
        if (instr_valid && instr_ready) begin
          w = mem_word(exp_pc);
          check_eq("sb_nbytes", 32'(nbytes), 32'd4);
          check_eq("sb_instr_pc", 32'(instr_pc), 32'(exp_pc));
          check_eq("sb_instr", instr, w);
          check_eq("sb_illegal", 32'(instr_illegal), 32'(w[1:0] != 2'b11));
          exp_pc = exp_pc + 16'd4;
          nbytes = 0;
          n_retired++;
        end
      end
    end
  end

  task automatic wait_valid(input string tag, output int hits);
    int n;
    n = 0;
    hits = 0;
    while (!instr_valid && n < 40) begin
      if (mem_req && mem_addr == STALL_ADDR) hits++;
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    int t0;
    int hits;
    int n;
    mem_ovr[16'h0000] = 8'h13;
    mem_ovr[16'h0001] = 8'h00;
    mem_ovr[16'h0002] = 8'h00;
    mem_ovr[16'h0003] = 8'h00;
    mem_ovr[16'h0200] = 8'h01;
    mem_ovr[16'h0201] = 8'h45;
    mem_ovr[16'h0202] = 8'h00;
    mem_ovr[16'h0203] = 8'h00;

    // Reset values
    #17;
    check_eq("rst_req", 32'(mem_req), 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", 32'(instr_pc), 32'h0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_illegal", 32'(instr_illegal), 32'd0);
    #5 rst_n = 1'b1;
    instr_ready = 1'b1;

    // Zero-wait fetch of 0x00000013
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_rise", 32'(mem_req), 32'd1);
    check_eq("first_addr", 32'(mem_addr), 32'h0);
    t0 = cyc;
    wait_valid("t1_valid", hits);
    check_eq("t1_latency", 32'(cyc - t0), 32'd4);
    check_eq("t1_instr", instr, 32'h0000_0013);
    check_eq("t1_instr_pc", 32'(instr_pc), 32'h0);
    check_eq("t1_illegal", 32'(instr_illegal), 32'd0);
    @(negedge clk);
    check_eq("t1_valid_drop", 32'(instr_valid), 32'd0);
    check_eq("t1_next_req", 32'(mem_req), 32'd1);
    check_eq("t1_next_addr", 32'(mem_addr), 32'h4);

    // Byte 2 stalled for 3 cycles
    instr_ready = 1'b0;
    t0 = cyc;
    wait_valid("t2_valid", hits);
    check_eq("t2_latency", 32'(cyc - t0), 32'd7);
    check_eq("t2_stall_cycles", 32'(hits), 32'd4);
    check_eq("t2_instr", instr, mem_word(16'h4));

    // Held in HOLD with ready low
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t3_valid", 32'(instr_valid), 32'd1);
      check_eq("t3_req", 32'(mem_req), 32'd0);
      check_eq("t3_instr", instr, mem_word(16'h4));
      check_eq("t3_instr_pc", 32'(instr_pc), 32'h4);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    check_eq("t3_valid_drop", 32'(instr_valid), 32'd0);
    check_eq("t3_next_addr", 32'(mem_addr), 32'h8);
    check_eq("t3_next_req", 32'(mem_req), 32'd1);

    // Redirect colliding with the ack of byte 1
    @(negedge clk);
    check_eq("t4_addr_b1", 32'(mem_addr), 32'h9);
    redirect = 1'b1;
    redirect_pc = 16'h0123;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("t4_redir_addr", 32'(mem_addr), 32'h0120);
    check_eq("t4_redir_req", 32'(mem_req), 32'd1);
    check_eq("t4_redir_valid", 32'(instr_valid), 32'd0);
    wait_valid("t4_valid", hits);
    check_eq("t4_instr_pc", 32'(instr_pc), 32'h0120);
    check_eq("t4_instr", instr, mem_word(16'h0120));

    // Redirect with ready in HOLD, to the top of the address space
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect = 1'b0;
    check_eq("t5_redir_addr", 32'(mem_addr), 32'hFFFC);
    check_eq("t5_redir_valid", 32'(instr_valid), 32'd0);
    wait_valid("t5_valid", hits);
    check_eq("t5_instr_pc", 32'(instr_pc), 32'hFFFC);
    check_eq("t5_instr", instr, mem_word(16'hFFFC));
    @(negedge clk);
    check_eq("t5_wrap_addr", 32'(mem_addr), 32'h0);
    check_eq("t5_wrap_req", 32'(mem_req), 32'd1);

    // Compressed encoding flagged, then async reset in HOLD
    instr_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid("t6_valid", hits);
    check_eq("t6_instr", instr, 32'h0000_4501);
    check_eq("t6_illegal", 32'(instr_illegal), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(instr_valid), 32'd0);
    check_eq("t6_rst_req", 32'(mem_req), 32'd0);
    check_eq("t6_rst_instr", instr, 32'h0);
    check_eq("t6_rst_instr_pc", 32'(instr_pc), 32'h0);
    check_eq("t6_rst_illegal", 32'(instr_illegal), 32'd0);
    #12 rst_n = 1'b1;

    // Randomized traffic
    rand_mode = 1'b1;
    repeat (2000) begin
      @(negedge clk);
      instr_ready = 1'($urandom_range(1));
      redirect = ($urandom_range(24) == 0);
      redirect_pc = 16'($urandom);
    end
    @(negedge clk);
    redirect = 1'b0;
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rand_progress", 32'(n_retired > 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
